// File: rtl/register_n_pkg.sv
// Datapath-wide constants shared by modules that instantiate register_n.
// register_n itself is sized only by its own parameters.
package register_n_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    typedef logic [DATA_WIDTH-1:0] data_t;

endpackage : register_n_pkg

// File: rtl/register_n.sv
// N-bit latch-every-cycle storage register with synchronous active-low clear.
// out is driven straight from the flops; there is no load enable and no hold mode.
module register_n #(
    parameter int             N           = 8,
    parameter logic [N-1:0]   RESET_VALUE = '0
) (
    output logic [N-1:0] out,
    input  logic [N-1:0] in,
    input  logic         clock,
    input  logic         reset
);

    if (N < 1) begin : g_width_check
        $fatal(1, "register_n: N must be at least 1");
    end

    logic [N-1:0] out_q;

    // Reset wins over data; in is ignored entirely while reset is low.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_q <= RESET_VALUE;
        end else begin
            out_q <= in;
        end
    end

    assign out = out_q;

    a_reset_loads: assert property (@(posedge clock) !reset |=> out == RESET_VALUE);
    a_data_loads:  assert property (@(posedge clock) reset |=> out == $past(in));

endmodule : register_n

// File: tb/tb_register_n.sv
// Directed bench for register_n: N=8/RESET_VALUE=0, plus N=1 and N=32 with a non-zero
// reset value, all sharing one clock (200 ns period, first rising edge at 100 ns).
module tb_register_n;
    import register_n_pkg::*;

    logic        clock;
    logic        reset;
    data_t       in8;
    data_t       out8;
    logic        in1;
    logic        out1;
    logic [31:0] in32;
    logic [31:0] out32;

    int checks   = 0;
    int failures = 0;

    register_n #(
        .N           (DATA_WIDTH),
        .RESET_VALUE (8'h00)
    ) u_dut8 (
        .out   (out8),
        .in    (in8),
        .clock (clock),
        .reset (reset)
    );

    register_n #(
        .N           (1),
        .RESET_VALUE (1'b0)
    ) u_dut1 (
        .out   (out1),
        .in    (in1),
        .clock (clock),
        .reset (reset)
    );

    register_n #(
        .N           (32),
        .RESET_VALUE (32'hDEADBEEF)
    ) u_dut32 (
        .out   (out32),
        .in    (in32),
        .clock (clock),
        .reset (reset)
    );

    initial begin
        clock = 1'b0;
        forever #100 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0] stream_vals [4];

    initial begin
        stream_vals[0] = 8'h01;
        stream_vals[1] = 8'hFF;
        stream_vals[2] = 8'h80;
        stream_vals[3] = 8'h55;

        reset = 1'b0;
        in8   = 8'h00;
        in1   = 1'b0;
        in32  = 32'h0000_0000;

        // Edges at 100 and 300 ns are sampled with reset low.
        #200;
        check_val("reset_hold_100_n8",  32'(out8),  32'h00);
        check_val("reset_hold_100_n1",  32'(out1),  32'h0);
        check_val("reset_hold_100_n32", out32,      32'hDEADBEEF);
        #50 in8 = 8'd10;
        in1  = 1'b1;
        in32 = 32'h1234_5678;
        #150;
        check_val("in_ignored_in_reset_n8",  32'(out8), 32'h00);
        check_val("in_ignored_in_reset_n1",  32'(out1), 32'h0);
        check_val("in_ignored_in_reset_n32", out32,     32'hDEADBEEF);

        // Release at 450 ns; edge at 500 ns loads in.
        #50 reset = 1'b1;
        #150;
        check_val("release_500", 32'(out8), 32'h0A);
        check_val("release_n32", out32,     32'h1234_5678);
        #200;
        check_val("hold_700", 32'(out8), 32'h0A);
        #200;
        check_val("hold_900", 32'(out8), 32'h0A);

        // Now at a falling edge (1000 ns): each new value shows up one edge later.
        for (int i = 0; i < 4; i++) begin
            in8 = stream_vals[i];
            #200;
            check_val($sformatf("stream_%0d", i), 32'(out8), 32'(stream_vals[i]));
        end

        // Mid-run single-cycle reset.
        in8 = 8'hA5;
        #200;
        check_val("pre_midreset", 32'(out8), 32'hA5);
        reset = 1'b0;
        in8   = 8'h3C;
        #200;
        check_val("midreset_clears",     32'(out8), 32'h00);
        check_val("midreset_clears_n32", out32,     32'hDEADBEEF);
        reset = 1'b1;
        #200;
        check_val("midreset_resume", 32'(out8), 32'h3C);

        // Glitches between edges must not reach out; only the value at the edge counts.
        in8 = 8'h11;
        #30 in8 = 8'h22;
        #20;
        check_val("glitch_not_visible", 32'(out8), 32'h3C);
        in8 = 8'h33;
        #150;
        check_val("glitch_final_value", 32'(out8), 32'h33);

        // Width sweep: all-ones then all-zeros pass through unchanged.
        in1  = 1'b1;
        in32 = 32'hFFFF_FFFF;
        #200;
        check_val("n1_ones",  32'(out1), 32'h1);
        check_val("n32_ones", out32,     32'hFFFF_FFFF);
        in1  = 1'b0;
        in32 = 32'h0000_0000;
        #200;
        check_val("n1_zeros",  32'(out1), 32'h0);
        check_val("n32_zeros", out32,     32'h0000_0000);

        // Simultaneous change of in and reset: reset at the edge decides.
        reset = 1'b0;
        in1   = 1'b1;
        in32  = 32'hCAFE_F00D;
        #200;
        check_val("n32_reset_again", out32, 32'hDEADBEEF);
        check_val("n1_reset_again",  32'(out1), 32'h0);
        reset = 1'b1;
        #200;
        check_val("n32_after_reset", out32,     32'hCAFE_F00D);
        check_val("n1_after_reset",  32'(out1), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_register_n
